// File: rtl/inv_shift_rows_serial.sv
// InvShiftRows stage for the 16-bit AES decrypt datapath: buffers one
// 128-bit state received as eight 16-bit beats, then streams it back out
// as eight beats with row r rotated right by r columns.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   clr               synchronous abort of any partial or pending block
//   in_data/valid/last/ready    input beat stream (8 beats per block)
//   out_data/valid/last/ready   output beat stream (8 beats per block)
//   frame_err         one-cycle pulse when in_last disagrees with beat 8
module inv_shift_rows_serial #(
    parameter int BEAT_W = 16,
    parameter int BEATS  = 128 / BEAT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic [BEAT_W-1:0] in_data,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [BEAT_W-1:0] out_data,
    output logic              out_valid,
    output logic              out_last,
    input  logic              out_ready,
    output logic              frame_err
);

    typedef enum logic {
        FILL = 1'b0,
        EMIT = 1'b1
    } state_t;

    localparam logic [2:0] LAST_CNT = 3'(BEATS - 1);

    state_t     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       in_fire;

    // Byte-addressed state buffer, column-major: index 4c+r.
    logic [7:0] buf_q [16];
    logic [7:0] perm  [16];

    // Row r of the output is row r of the input rotated right by r
    // columns, so output column c reads input column (c-r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_col
        for (genvar r = 0; r < 4; r++) begin : g_row
            assign perm[4*c+r] = buf_q[4*((c-r+4)%4)+r];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Partial blocks dropped by a framing error or clr leave stale bytes
    // behind; they are always overwritten before the next EMIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                buf_q[i] <= '0;
            end
        end else if (in_fire) begin
            buf_q[{cnt_q, 1'b0}] <= in_data[15:8];
            buf_q[{cnt_q, 1'b1}] <= in_data[7:0];
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = 1'b0;
        in_fire = 1'b0;
        if (clr) begin
            state_d = FILL;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                FILL: begin
                    if (in_valid) begin
                        in_fire = 1'b1;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d = '0;
                            if (in_last) begin
                                state_d = EMIT;
                            end else begin
                                err_d = 1'b1;
                            end
                        end else if (in_last) begin
                            cnt_d = '0;
                            err_d = 1'b1;
                        end else begin
                            cnt_d = cnt_q + 3'd1;
                        end
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == LAST_CNT) begin
                            state_d = FILL;
                        end
                    end
                end
                default: begin
                    state_d = FILL;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign in_ready  = (state_q == FILL);
    assign out_valid = (state_q == EMIT);
    assign out_last  = (state_q == EMIT) && (cnt_q == LAST_CNT);
    assign frame_err = err_q;
    assign out_data  = (state_q == EMIT)
                     ? {perm[{cnt_q, 1'b0}], perm[{cnt_q, 1'b1}]}
                     : '0;

endmodule

// File: doc/inv_shift_rows_serial.md
Name: inv_shift_rows_serial

Overview:
- Decryption-side InvShiftRows stage for the 16-bit AES datapath. It is the inverse of the encryption-side ShiftRows.
- Receives a 128-bit AES state as eight 16-bit beats over a valid/ready stream, buffers the full block, and applies InvShiftRows.
- Streams the result out as eight 16-bit beats.
- Sits between the InvSubBytes serialiser and AddRoundKey in the decrypt round loop.

Parameters:
- BEAT_W, 16, beat width in bits. 16 is the only supported value.
- BEATS, 8, beats per 128-bit block. Derived as 128/BEAT_W; must not be overridden.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous abort: drops any partial or pending block.
- in_data  in  16  input beat.
- in_valid  in  1  input beat valid.
- in_last  in  1  marks the final (8th) beat of a block.
- in_ready  out  1  block can accept an input beat.
- out_data  out  16  output beat.
- out_valid  out  1  output beat valid.
- out_last  out  1  asserted with the 8th output beat.
- out_ready  in  1  downstream accepts the output beat.
- frame_err  out  1  one-cycle pulse on a framing error.

Behaviour:
- Byte order:
  - State bytes s0..s15 are column-major: s(4c+r) is row r, column c.
  - Beat k (k=0..7) carries s(2k) in [15:8] and s(2k+1) in [7:0]. Beat 0 is first.
- Transform: out[4c+r] = in[4*((c-r) mod 4)+r], all indices mod 4 in c. Row 0 unchanged, row r rotated right by r columns.
- Reset (rst_n low, asynchronous):
  - State goes to FILL, beat counter to 0.
  - in_ready=1, out_valid=0, out_last=0, frame_err=0, out_data=0.
  - The 128-bit buffer is cleared to 0.
- FSM states, FILL and EMIT:
  - FILL:
    - in_ready=1, out_valid=0.
    - A beat is accepted when in_valid and in_ready are both high. It is written into buffer slot cnt, and cnt increments.
    - On the accepted beat with cnt=7: cnt goes to 0 and the state goes to EMIT.
  - EMIT:
    - in_ready=0. out_valid=1, starting the cycle after the 8th input beat is accepted.
    - out_data is output beat cnt of the InvShiftRows-permuted buffer. The permutation is combinational on the buffer, with the output registered or muxed by cnt.
    - A beat is transferred when out_valid and out_ready are both high; cnt then increments.
    - out_last=1 when cnt=7.
    - On transfer of the beat with cnt=7: state goes to FILL and cnt to 0. in_ready=1 in the next cycle.
- Latency and throughput:
  - First output beat is valid 1 cycle after the last input beat is accepted.
  - One block per 16 cycles minimum (8 in, 8 out). No overlap of fill and drain.
- Backpressure: while out_ready=0, out_data, out_valid and out_last hold stable. cnt does not advance.
- Input stalls: in_valid=0 mid-block holds cnt. There is no timeout.
- Framing errors:
  - in_last=1 on an accepted beat with cnt≠7: frame_err pulses for 1 cycle, the partial block is discarded, cnt goes to 0, state stays FILL.
  - in_last=0 on the accepted beat with cnt=7: frame_err pulses and the block is discarded. Nothing is emitted; state stays FILL, cnt goes to 0.
- clr:
  - Takes priority over all handshakes in the same cycle.
  - Next state is FILL, cnt=0, out_valid=0, out_last=0.
  - Any beat presented that cycle is not accepted.
  - Buffer contents are don't-care.
  - frame_err is not asserted on clr.
- Reset mid-block: all state is lost immediately and no partial output is produced.

Test Plan:
- Reset values: assert rst_n low mid-EMIT with out_ready=1 → out_valid drops immediately (asynchronously); after release in_ready=1, out_valid=0, frame_err=0.
- Basic transform:
  - Stimulus: feed s_i=i (beats 0001,0203,0405,0607,0809,0A0B,0C0D,0E0F, in_last on the 8th), out_ready=1.
  - Response: out beats 000D,0A07,0401,0E0B,0805,020F,0C09,0603; out_last on 0603; out_valid the cycle after the 8th input beat.
- Round trip:
  - Stimulus: feed the forward-ShiftRows result of 0..F (beats 0005,0A0F,0409,0E03,080D,0207,0C01,060B).
  - Response: output 0001,0203,...,0E0F.
- Backpressure and stalls:
  - Stimulus: random in_valid gaps, and out_ready low for 3 cycles on output beat 4.
  - Response: out_data holds 0805 stable while stalled; no beat lost or duplicated; in_ready=0 throughout EMIT.
- Framing errors:
  - in_last on beat 3 → frame_err one-cycle pulse, nothing emitted; the next correct block is emitted correctly.
  - No in_last on beat 8 → same response.
- clr:
  - clr after 5 input beats → those beats are discarded; the next 8-beat block is emitted alone.
  - clr during EMIT with out_ready=0 → out_valid=0 the next cycle, in_ready=1.
